fpga_rst_seq: RTL
=================

FPGA_RST_SEQ -- requirements
Module: fpga_rst_seq

Interface
REQ-001 SHALL have parameter DebounceCycles, default 50000: cycles the button level must hold stable before it is accepted (1 ms at 50 MHz).
REQ-002 SHALL have parameter HoldCycles, default 1024: minimum cycles in HOLD with no reset request pending.
REQ-003 SHALL have parameter CalibTimeout, default 2**24: maximum cycles spent in WAIT_DRAM.
REQ-004 SHALL have clk_i, input, 1: the single clock, the SoC clock; it is the only clock in the block.
REQ-005 SHALL have rst_ni, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have btn_rst_i, input, 1: raw board reset button, active-high, asynchronous to clk_i.
REQ-007 SHALL have vio_rst_i, input, 1: debug reset, active-high, synchronous to clk_i.
REQ-008 SHALL have clk_locked_i, input, 1: clock generator lock, asynchronous.
REQ-009 SHALL have dram_calib_done_i, input, 1: memory controller calibration done, asynchronous.
REQ-010 SHALL have dram_en_i, input, 1: static strap; 1 means wait for calibration.
REQ-011 SHALL have dram_rst_o, output, 1: memory controller reset, active-high.
REQ-012 SHALL have soc_rst_no, output, 1: SoC reset, active-low, feeds the downstream reset synchronizer.
REQ-013 SHALL have state_o, output, 2: current state for debug.
REQ-014 SHALL have calib_timeout_o, output, 1: sticky flag, calibration timed out.

Function
REQ-015 SHALL synchronize btn_rst_i, clk_locked_i and dram_calib_done_i through two flops each.
REQ-016 SHALL change the debounced button level only after the synchronized level differs from it for DebounceCycles consecutive cycles; any bounce SHALL restart the count.
REQ-017 SHALL form the reset request as: debounced button OR vio_rst_i OR NOT synchronized lock.
REQ-018 SHALL implement the states HOLD=2'b00, WAIT_DRAM=2'b01 and RUN=2'b10; the value 2'b11 is unreachable and SHALL decode to HOLD.
REQ-019 In HOLD, outputs SHALL be dram_rst_o=1 and soc_rst_no=0; the hold counter SHALL clear on every cycle with a request, and otherwise increment.
REQ-020 HOLD SHALL go to WAIT_DRAM on the cycle the hold counter equals HoldCycles-1 with no request present.
REQ-021 In WAIT_DRAM, outputs SHALL be dram_rst_o=0 and soc_rst_no=0; the timeout counter SHALL start from 0 on entry.
REQ-022 WAIT_DRAM SHALL go to RUN when synchronized calibration is 1, or when dram_en_i=0 (one cycle in WAIT_DRAM).
REQ-023 WAIT_DRAM SHALL go to RUN and set calib_timeout_o when the timeout counter equals CalibTimeout-1.
REQ-024 In RUN, outputs SHALL be dram_rst_o=0 and soc_rst_no=1.
REQ-025 A request in any state SHALL force HOLD on the next edge; a request SHALL take priority over every other transition in the same cycle.
REQ-026 SHALL register all outputs; from vio_rst_i high at cycle N, soc_rst_no SHALL be 0 at cycle N+1.
REQ-027 Latency from a stable btn_rst_i edge to soc_rst_no=0 SHALL be 2+DebounceCycles+1 cycles.
REQ-028 calib_timeout_o SHALL clear only on rst_ni; re-entering HOLD SHALL NOT clear it.
REQ-029 Loss of calibration in RUN SHALL be ignored; loss of lock in RUN SHALL be treated as a request.
REQ-030 Counter widths SHALL be $clog2(param+1); elaboration SHALL fail if any parameter is less than 1.

Reset
REQ-031 On rst_ni=0, the following SHALL hold asynchronously: state=HOLD, dram_rst_o=1, soc_rst_no=0, all counters=0, synchronizers=0, debounced level=0, calib_timeout_o=0.
REQ-032 A reset asserted mid-sequence SHALL restart the full HOLD period after release.

Structure
REQ-033 The state enum rst_seq_state_e and the default parameter constants SHALL live in the shared FPGA target package.
REQ-034 Synchronizers SHALL reuse the common-cells sync cell.
REQ-035 The debouncer SHALL be one sub-module, rst_btn_debounce, parameterized by DebounceCycles.

Verification (DebounceCycles=4, HoldCycles=8, CalibTimeout=32)
REQ-036 Scenario 1: release rst_ni with lock=1, calib rising 5 cycles after WAIT_DRAM entry -> HOLD 8 cycles, WAIT_DRAM 5+2 cycles, then soc_rst_no=1 and state_o=2'b10.
REQ-037 Scenario 2: btn pulses 1,0,1 of 2 cycles each -> no state change; btn held 10 cycles -> soc_rst_no=0 seven cycles after the stable edge.
REQ-038 Scenario 3: vio_rst_i single-cycle pulse in RUN -> HOLD next cycle, then HoldCycles before WAIT_DRAM.
REQ-039 Scenario 4: calib never rises, dram_en_i=1 -> RUN after 32 cycles in WAIT_DRAM, calib_timeout_o=1 and still 1 after a later vio reset.
REQ-040 Scenario 5: dram_en_i=0 -> exactly one cycle in WAIT_DRAM, then RUN.
REQ-041 Scenario 6: lock drops in cycle 3 of HOLD -> hold counter restarts; rst_ni pulsed low mid-WAIT_DRAM -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/fpga_rst_seq_pkg.sv
// Shared FPGA target definitions: reset-sequencer state encoding and default timing constants.
package fpga_rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD      = 2'b00,
        ST_WAIT_DRAM = 2'b01,
        ST_RUN       = 2'b10
    } rst_seq_state_e;

    localparam int unsigned DefDebounceCycles = 50000;
    localparam int unsigned DefHoldCycles     = 1024;
    localparam int unsigned DefCalibTimeout   = 2**24;

endpackage

// File: rtl/fpga_rst_seq_debounce.sv
// Button debouncer: the output level follows the input only after it has differed for
// DebounceCycles consecutive cycles; any return to the current level restarts the count.
module rst_btn_debounce
    import fpga_rst_seq_pkg::*;
#(
    parameter int unsigned DebounceCycles = DefDebounceCycles
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic btn_o
);

    localparam int unsigned CntW = $clog2(DebounceCycles + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (btn_i != level_q) begin
            if (cnt_q == CntW'(DebounceCycles - 1)) begin
                level_d = btn_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign btn_o = level_q;

endmodule

// File: rtl/sync.sv
// Common-cells style multi-stage synchronizer for a single asynchronous level.
module sync #(
    parameter int unsigned STAGES     = 2,
    parameter logic        ResetValue = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic serial_i,
    output logic serial_o
);

    logic [STAGES-1:0] reg_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_q <= {STAGES{ResetValue}};
        end else begin
            reg_q <= {reg_q[STAGES-2:0], serial_i};
        end
    end

    assign serial_o = reg_q[STAGES-1];

endmodule

// File: rtl/fpga_rst_seq.sv
// Board reset sequencer: holds DRAM and SoC in reset, releases DRAM, waits for calibration
// (or timeout), then releases the SoC. Any reset request returns to HOLD.
module fpga_rst_seq
    import fpga_rst_seq_pkg::*;
#(
    parameter int unsigned DebounceCycles = DefDebounceCycles,
    parameter int unsigned HoldCycles     = DefHoldCycles,
    parameter int unsigned CalibTimeout   = DefCalibTimeout
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       btn_rst_i,
    input  logic       vio_rst_i,
    input  logic       clk_locked_i,
    input  logic       dram_calib_done_i,
    input  logic       dram_en_i,
    output logic       dram_rst_o,
    output logic       soc_rst_no,
    output logic [1:0] state_o,
    output logic       calib_timeout_o
);

    if (DebounceCycles < 1 || HoldCycles < 1 || CalibTimeout < 1) begin : g_bad_param
        $error("fpga_rst_seq: all cycle parameters must be at least 1");
    end

    localparam int unsigned HoldW = $clog2(HoldCycles + 1);
    localparam int unsigned TmoW  = $clog2(CalibTimeout + 1);

    logic btn_sync, lock_sync, calib_sync, btn_deb, req;

    sync #(.STAGES(2), .ResetValue(1'b0)) u_sync_btn (
        .clk_i(clk_i), .rst_ni(rst_ni), .serial_i(btn_rst_i), .serial_o(btn_sync)
    );
    sync #(.STAGES(2), .ResetValue(1'b0)) u_sync_lock (
        .clk_i(clk_i), .rst_ni(rst_ni), .serial_i(clk_locked_i), .serial_o(lock_sync)
    );
    sync #(.STAGES(2), .ResetValue(1'b0)) u_sync_calib (
        .clk_i(clk_i), .rst_ni(rst_ni), .serial_i(dram_calib_done_i), .serial_o(calib_sync)
    );

    rst_btn_debounce #(.DebounceCycles(DebounceCycles)) u_debounce (
        .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_sync), .btn_o(btn_deb)
    );

    assign req = btn_deb | vio_rst_i | ~lock_sync;

    rst_seq_state_e  state_q;
    logic [HoldW-1:0] hold_cnt_q;
    logic [TmoW-1:0]  tmo_cnt_q;
    logic             dram_rst_q, soc_rst_n_q, timeout_q;

    // Outputs are registered alongside the state so they always reflect state_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            dram_rst_q  <= 1'b1;
            soc_rst_n_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else if (req) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            dram_rst_q  <= 1'b1;
            soc_rst_n_q <= 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_DRAM: begin
                    if (calib_sync || !dram_en_i) begin
                        state_q     <= ST_RUN;
                        soc_rst_n_q <= 1'b1;
                    end else if (tmo_cnt_q == TmoW'(CalibTimeout - 1)) begin
                        state_q     <= ST_RUN;
                        soc_rst_n_q <= 1'b1;
                        timeout_q   <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    // Also recovers the unused 2'b11 encoding into HOLD.
                    dram_rst_q  <= 1'b1;
                    soc_rst_n_q <= 1'b0;
                    if (hold_cnt_q == HoldW'(HoldCycles - 1)) begin
                        state_q    <= ST_WAIT_DRAM;
                        tmo_cnt_q  <= '0;
                        dram_rst_q <= 1'b0;
                    end else begin
                        state_q    <= ST_HOLD;
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign state_o         = state_q;
    assign dram_rst_o      = dram_rst_q;
    assign soc_rst_no      = soc_rst_n_q;
    assign calib_timeout_o = timeout_q;

endmodule
